matrix_bram_writer: RTL and testbench
=====================================

# matrix_bram_writer

Upstream loader for the dual-port matrix BRAM pool. It accepts a store command (base address, rows, cols), then accepts exactly rows×cols element beats on a valid/ready stream and issues one Port A write per beat in row-major order at consecutive addresses. It signals completion, supports abort, and optionally range-checks commands against the BRAM depth. It sits between the input/parse front end and Port A of the memory pool.

## Interface
- DATA_WIDTH, 4: element width; matches the BRAM word.
- ADDR_WIDTH, 12: BRAM address width.
- DEPTH, 4096: BRAM word count; used by the bounds check.
- MAX_DIM, 5: largest legal rows/cols value.
- DIM_WIDTH, 3: width of the rows/cols fields.

Ports:
- clk  in  1  sole clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  writer can accept a command.
- cmd_base  in  ADDR_WIDTH  address of element (0,0).
- cmd_rows  in  DIM_WIDTH  row count.
- cmd_cols  in  DIM_WIDTH  column count.
- in_valid  in  1  element beat offered.
- in_ready  out  1  writer accepts an element.
- in_data  in  DATA_WIDTH  element value.
- abort  in  1  cancel the current load.
- a_en  out  1  BRAM Port A enable.
- a_we  out  1  BRAM Port A write enable.
- a_addr  out  ADDR_WIDTH  BRAM Port A address.
- a_din  out  DATA_WIDTH  BRAM Port A write data.
- busy  out  1  a load is in progress.
- done  out  1  one-cycle pulse when the last element has been written.
- err  out  1  one-cycle pulse when a command is rejected.
- wr_count  out  2*DIM_WIDTH  elements written in the current or last load.

## Operation
- **States:** IDLE, LOAD, DONE.
- **IDLE**
  - cmd_ready=1, in_ready=0.
  - A command is accepted on cmd_valid&&cmd_ready. The writer latches base, rows, cols, total=rows*cols (2*DIM_WIDTH bits, unsigned), clears wr_count and goes to LOAD.
  - A command with rows==0, cols==0, rows>MAX_DIM or cols>MAX_DIM is rejected: err pulses, the writer stays in IDLE and issues no writes.
- **LOAD**
  - in_ready=1, busy=1.
  - Each in_valid&&in_ready beat registers a write: a_en=a_we=1, a_addr=base+wr_count (mod 2^ADDR_WIDTH), a_din=in_data. wr_count then increments.
  - When the beat that makes wr_count==total is accepted, the next state is DONE.
  - in_ready drops in the same cycle as that final handshake is registered, so no extra beat is accepted.
- **DONE**
  - Lasts one cycle: done=1, busy=0. Then returns to IDLE.
- **abort**
  - Only meaningful in LOAD. The next state is IDLE, there is no done pulse and wr_count holds the partial count.
  - A beat presented in the same cycle as abort is not accepted (in_ready is gated by !abort).
  - abort in IDLE or DONE is ignored.
- a_en and a_we are asserted only for write cycles; the writer never reads.
- cmd_base and the dimension inputs are sampled only at command acceptance; later changes have no effect.

## Timing
- **Reset values:** state=IDLE, cmd_ready=0 during reset then 1, in_ready=0, a_en=0, a_we=0, a_addr=0, a_din=0, busy=0, done=0, err=0, wr_count=0.
- Reset mid-load discards the load immediately with no done pulse.
- Command accepted at edge N → in_ready=1 and busy=1 from cycle N+1.
- Beat accepted at edge K → a_en/a_we/a_addr/a_din valid during cycle K+1, written to BRAM at edge K+1.
- The final beat at edge K → done=1 during cycle K+1 (the same cycle as the last write strobe), and cmd_ready=1 at cycle K+2.
- Throughput is one element per cycle. Back-pressure comes only from the upstream in_valid.
- err asserts in the cycle after the rejected command is sampled.

## Configuration
- **BOUNDS_CHECK_EN defined:** a command with base+total > DEPTH is also rejected with an err pulse. Address wrap therefore cannot occur.
- **BOUNDS_CHECK_EN undefined:** no depth check. a_addr wraps modulo 2^ADDR_WIDTH. Dimension checks (zero, >MAX_DIM) are always present.

## Test plan
- **Basic 2×3 load:** cmd base=0x010, rows=2, cols=3, then six back-to-back beats 1..6 → writes at 0x010..0x015 with data 1..6, done pulses once, wr_count=6.
- **Gapped valid:** a 5×5 load with in_valid toggling every other cycle → 25 writes at consecutive addresses, no duplicates or drops, done after the 25th write.
- **Illegal dimensions:** cmd rows=0 cols=3, then rows=6 cols=2 → err pulses twice, a_we never asserted, cmd_ready stays 1.
- **Abort:** abort asserted after 4 of 9 beats of a 3×3 load, with in_valid high → exactly 4 writes, no done pulse, wr_count=4, the next command accepted normally.
- **Wrap/bounds:** base=0xFFE, 2×2 load:
  - With BOUNDS_CHECK_EN → err and no writes.
  - Without it → writes at 0xFFE, 0xFFF, 0x000, 0x001.
- **Reset mid-load:** rst for 1 cycle during a 4×4 load → all outputs at reset values the next cycle, no done pulse, the next command is processed from wr_count=0.

Source files
------------

// File: rtl/matrix_bram_writer_if.sv
// Command, element stream and BRAM Port A signal bundle for matrix_bram_writer.
interface matrix_bram_writer_if #(
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DIM_WIDTH  = 3
);
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [ADDR_WIDTH-1:0]    cmd_base;
    logic [DIM_WIDTH-1:0]     cmd_rows;
    logic [DIM_WIDTH-1:0]     cmd_cols;
    logic                     in_valid;
    logic                     in_ready;
    logic [DATA_WIDTH-1:0]    in_data;
    logic                     abort;
    logic                     a_en;
    logic                     a_we;
    logic [ADDR_WIDTH-1:0]    a_addr;
    logic [DATA_WIDTH-1:0]    a_din;
    logic                     busy;
    logic                     done;
    logic                     err;
    logic [2*DIM_WIDTH-1:0]   wr_count;

    modport master (
        output cmd_valid, cmd_base, cmd_rows, cmd_cols, in_valid, in_data, abort,
        input  cmd_ready, in_ready, a_en, a_we, a_addr, a_din, busy, done, err, wr_count
    );

    modport slave (
        input  cmd_valid, cmd_base, cmd_rows, cmd_cols, in_valid, in_data, abort,
        output cmd_ready, in_ready, a_en, a_we, a_addr, a_din, busy, done, err, wr_count
    );
endinterface

// File: rtl/matrix_bram_writer.sv
// Loads a rows x cols matrix into BRAM Port A in row-major order from a valid/ready stream.
// Optional BOUNDS_CHECK_EN macro rejects commands whose footprint exceeds DEPTH.
module matrix_bram_writer #(
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DEPTH      = 4096,
    parameter int unsigned MAX_DIM    = 5,
    parameter int unsigned DIM_WIDTH  = 3
) (
    input  logic                clk,
    input  logic                rst,
    matrix_bram_writer_if.slave bus
);
    localparam int unsigned CNT_W = 2 * DIM_WIDTH;

`ifdef BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [CNT_W-1:0]        total_q, total_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    a_en_q, a_en_d;
    logic [ADDR_WIDTH-1:0]   a_addr_q, a_addr_d;
    logic [DATA_WIDTH-1:0]   a_din_q, a_din_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;

    logic                    cmd_fire;
    logic                    beat_fire;
    logic                    dim_bad;
    logic                    range_bad;
    logic [CNT_W-1:0]        cmd_total;

    // Readies are decoded from state so a handshake never lands during reset or abort.
    assign bus.cmd_ready = (state_q == IDLE) && !rst;
    assign bus.in_ready  = (state_q == LOAD) && !bus.abort && !rst;

    assign cmd_fire  = bus.cmd_valid && bus.cmd_ready;
    assign beat_fire = bus.in_valid && bus.in_ready;
    assign cmd_total = CNT_W'(bus.cmd_rows) * CNT_W'(bus.cmd_cols);
    assign dim_bad   = (bus.cmd_rows == '0) || (bus.cmd_cols == '0) ||
                       (32'(bus.cmd_rows) > MAX_DIM) || (32'(bus.cmd_cols) > MAX_DIM);
    assign range_bad = BOUNDS_EN && ((32'(bus.cmd_base) + 32'(cmd_total)) > DEPTH);

    // Next-state and next-output decode.
    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        total_d  = total_q;
        cnt_d    = cnt_q;
        a_en_d   = 1'b0;
        a_addr_d = a_addr_q;
        a_din_d  = a_din_q;
        done_d   = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    if (dim_bad || range_bad) begin
                        err_d = 1'b1;
                    end else begin
                        base_d  = bus.cmd_base;
                        total_d = cmd_total;
                        cnt_d   = '0;
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (beat_fire) begin
                    a_en_d   = 1'b1;
                    a_addr_d = base_q + ADDR_WIDTH'(cnt_q);
                    a_din_d  = bus.in_data;
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (cnt_d == total_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == LOAD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base_q   <= '0;
            total_q  <= '0;
            cnt_q    <= '0;
            a_en_q   <= 1'b0;
            a_addr_q <= '0;
            a_din_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            base_q   <= base_d;
            total_q  <= total_d;
            cnt_q    <= cnt_d;
            a_en_q   <= a_en_d;
            a_addr_q <= a_addr_d;
            a_din_q  <= a_din_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign bus.a_en     = a_en_q;
    assign bus.a_we     = a_en_q;
    assign bus.a_addr   = a_addr_q;
    assign bus.a_din    = a_din_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.wr_count = cnt_q;
endmodule

// File: tb/tb_matrix_bram_writer.sv
// Randomized bench for matrix_bram_writer against a list-of-writes reference model.
module tb_matrix_bram_writer;
    localparam int unsigned AW    = 12;
    localparam int unsigned DW    = 4;
    localparam int unsigned DIMW  = 3;
    localparam int unsigned DEPTH = 4096;
    localparam int unsigned MAXD  = 5;
`ifdef BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;
    int   done_cnt = 0;
    int   err_cnt = 0;
    int   act_addr[$];
    int   act_data[$];
    int   act_we[$];

    matrix_bram_writer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DIM_WIDTH(DIMW)) bus();

    matrix_bram_writer #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .MAX_DIM(MAXD), .DIM_WIDTH(DIMW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Record every Port A strobe and every done/err pulse.
    always @(negedge clk) begin
        if (bus.a_en === 1'b1) begin
            act_addr.push_back(int'(bus.a_addr));
            act_data.push_back(int'(bus.a_din));
            act_we.push_back(int'(bus.a_we));
        end
        if (bus.done === 1'b1) done_cnt++;
        if (bus.err === 1'b1) err_cnt++;
    end

    task automatic clear_log();
        act_addr.delete();
        act_data.delete();
        act_we.delete();
        done_cnt = 0;
        err_cnt  = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, bus.cmd_ready, 0);
        chk({tag, "_in_ready"}, bus.in_ready, 0);
        chk({tag, "_a_en"}, bus.a_en, 0);
        chk({tag, "_a_we"}, bus.a_we, 0);
        chk({tag, "_a_addr"}, bus.a_addr, 0);
        chk({tag, "_a_din"}, bus.a_din, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_err"}, bus.err, 0);
        chk({tag, "_wr_count"}, bus.wr_count, 0);
    endtask

    // gap: 0 = back-to-back, 1 = valid every other cycle, 2 = random valid.
    task automatic run_cmd(input int base, input int rows, input int cols,
                           input int gap, input int abort_at, input bit seq_data);
        int  n;
        bit  legal;
        int  dat[$];
        int  acc;
        int  cyc;
        int  exp_writes;
        bit  v;
        bit  ab;
        bit  aborted;

        n     = rows * cols;
        legal = (rows >= 1) && (rows <= int'(MAXD)) && (cols >= 1) && (cols <= int'(MAXD)) &&
                !(BOUNDS && (base + n > int'(DEPTH)));
        clear_log();
        for (int i = 0; i < n; i++) dat.push_back(seq_data ? (i + 1) % 16 : int'($urandom_range(15)));

        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_base  = AW'(base);
        bus.cmd_rows  = DIMW'(rows);
        bus.cmd_cols  = DIMW'(cols);
        bus.abort     = 1'($urandom_range(1));
        #1 chk("cmd_ready_idle", bus.cmd_ready, 1);

        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.abort     = 1'b0;
        bus.cmd_base  = AW'($urandom);
        bus.cmd_rows  = DIMW'($urandom);
        bus.cmd_cols  = DIMW'($urandom);

        if (!legal) begin
            #1;
            chk("rej_err_pulse", bus.err, 1);
            chk("rej_busy", bus.busy, 0);
            chk("rej_cmd_ready", bus.cmd_ready, 1);
            @(negedge clk);
            #1 chk("rej_err_clear", bus.err, 0);
            repeat (2) @(negedge clk);
            chk("rej_writes", act_addr.size(), 0);
            chk("rej_err_cnt", err_cnt, 1);
            chk("rej_done_cnt", done_cnt, 0);
            return;
        end

        acc = 0;
        cyc = 0;
        aborted = 1'b0;
        while (acc < n && !aborted) begin
            ab = (abort_at >= 0) && (acc == abort_at);
            case (gap)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = ($urandom_range(99) >= 40);
            endcase
            bus.in_valid = v;
            bus.in_data  = DW'(dat[acc]);
            bus.abort    = ab;
            #1;
            chk("in_ready", bus.in_ready, !ab);
            chk("busy_load", bus.busy, 1);
            chk("wr_count_run", bus.wr_count, acc);
            if (ab) aborted = 1'b1;
            else if (v) acc++;
            cyc++;
            if (cyc > 2000) begin
                chk("beat_timeout", 1, 0);
                break;
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.abort    = 1'b0;
        #1;
        if (aborted) begin
            chk("abort_busy", bus.busy, 0);
            chk("abort_cmd_ready", bus.cmd_ready, 1);
            chk("abort_done", bus.done, 0);
            chk("abort_wr_count", bus.wr_count, acc);
        end else begin
            chk("done_pulse", bus.done, 1);
            chk("done_busy", bus.busy, 0);
            chk("done_in_ready", bus.in_ready, 0);
            chk("done_cmd_ready", bus.cmd_ready, 0);
            chk("final_wr_count", bus.wr_count, n);
            @(negedge clk);
            #1;
            chk("post_done", bus.done, 0);
            chk("post_cmd_ready", bus.cmd_ready, 1);
        end
        @(negedge clk);

        exp_writes = aborted ? abort_at : n;
        chk("write_count", act_addr.size(), exp_writes);
        for (int i = 0; i < act_addr.size() && i < exp_writes; i++) begin
            chk("wr_addr", act_addr[i], (base + i) % (1 << AW));
            chk("wr_data", act_data[i], dat[i]);
            chk("wr_we", act_we[i], 1);
        end
        chk("done_cnt", done_cnt, aborted ? 0 : 1);
        chk("err_cnt", err_cnt, 0);
    endtask

    task automatic reset_mid_load();
        clear_log();
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_base  = AW'(12'h100);
        bus.cmd_rows  = DIMW'(4);
        bus.cmd_cols  = DIMW'(4);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.in_data = DW'($urandom);
            @(negedge clk);
        end
        rst = 1'b1;
        @(posedge clk);
        #1 check_reset_outputs("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_done_cnt", done_cnt, 0);
        chk("rst_writes", act_addr.size(), 5);
    endtask

    initial begin
        int base;
        int abort_at;
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_base  = '0;
        bus.cmd_rows  = '0;
        bus.cmd_cols  = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.abort     = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        #1 chk("cmd_ready_after_reset", bus.cmd_ready, 1);

        run_cmd(12'h010, 2, 3, 0, -1, 1'b1);
        run_cmd(12'h200, 5, 5, 1, -1, 1'b0);
        run_cmd(12'h040, 0, 3, 0, -1, 1'b0);
        run_cmd(12'h040, 6, 2, 0, -1, 1'b0);
        run_cmd(12'h300, 3, 3, 0, 4, 1'b0);
        run_cmd(12'h301, 2, 2, 0, -1, 1'b0);
        run_cmd(12'hFFE, 2, 2, 0, -1, 1'b1);
        reset_mid_load();
        run_cmd(12'h123, 2, 2, 2, -1, 1'b0);

        for (int t = 0; t < 40; t++) begin
            base = ($urandom_range(3) == 0) ? 4096 - int'($urandom_range(25, 1))
                                            : int'($urandom_range(4095));
            abort_at = ($urandom_range(4) == 0) ? int'($urandom_range(24)) : -1;
            run_cmd(base, int'($urandom_range(7)), int'($urandom_range(7)),
                    int'($urandom_range(2)), abort_at, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
